// File: rtl/uart_rx_capture_if.sv
// Write-port bundle from the UART capture engine toward the BRAM write side,
// plus the message status strobes that accompany those writes.
interface uart_rx_capture_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  we;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [7:0]            w_data;
  logic                  msg_done;
  logic [ADDR_WIDTH-1:0] msg_len;
  logic                  overflow;
  logic                  frame_err;

  modport master (
    output we, w_addr, w_data, msg_done, msg_len, overflow, frame_err
  );

  modport slave (
    input we, w_addr, w_data, msg_done, msg_len, overflow, frame_err
  );
endinterface

// File: rtl/uart_rx_capture.sv
// 8N1 UART receiver with 16x oversampling feeding a message-capture engine that
// writes each byte to a BRAM port and stores the message terminator as 0x00.
module uart_rx_capture #(
  parameter int          DVSR       = 54,
  parameter int          SB_TICK    = 16,
  parameter int          ADDR_WIDTH = 8,
  parameter logic [7:0]  TERM_CHAR  = 8'h0D
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rx,
  uart_rx_capture_if.master wr
);
  localparam int CW = (DVSR > 1) ? $clog2(DVSR) : 1;
  localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = {ADDR_WIDTH{1'b1}};

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic          rx_meta_q, rx_sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick;

  state_t        state_q, state_d;
  logic [SW-1:0] s_q, s_d;
  logic [2:0]    n_q, n_d;
  logic [7:0]    b_q, b_d;
  logic          rx_done_q, rx_done_d;
  logic          ferr_q, ferr_d;

  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
  logic [7:0]            w_data_q, w_data_d;
  logic                  msg_done_q, msg_done_d;
  logic [ADDR_WIDTH-1:0] msg_len_q, msg_len_d;
  logic                  overflow_q, overflow_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;

  assign tick  = (cnt_q == CW'(DVSR - 1));
  assign cnt_d = tick ? '0 : cnt_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    n_d       = n_q;
    b_d       = b_q;
    rx_done_d = 1'b0;
    ferr_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_sync_q) begin
          state_d = START;
          s_d     = '0;
        end
      end
      START: begin
        if (tick) begin
          if (s_q == SW'(7)) begin
            s_d     = '0;
            n_d     = '0;
            // A start bit that is high again at its midpoint was only a glitch.
            state_d = rx_sync_q ? IDLE : DATA;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (s_q == SW'(15)) begin
            s_d = '0;
            b_d = {rx_sync_q, b_q[7:1]};
            n_d = n_q + 1'b1;
            if (n_q == 3'd7) state_d = STOP;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (s_q == SW'(SB_TICK - 1)) begin
            rx_done_d = rx_sync_q;
            ferr_d    = ~rx_sync_q;
            state_d   = IDLE;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    we_d       = 1'b0;
    msg_done_d = 1'b0;
    w_addr_d   = w_addr_q;
    w_data_d   = w_data_q;
    msg_len_d  = msg_len_q;
    overflow_d = overflow_q;
    addr_d     = addr_q;
    if (rx_done_q) begin
      we_d     = 1'b1;
      w_addr_d = addr_q;
      // The last slot is reserved for the terminator, so a full buffer closes the message.
      if ((b_q == TERM_CHAR) || (addr_q == ADDR_MAX)) begin
        w_data_d   = 8'h00;
        msg_done_d = 1'b1;
        msg_len_d  = addr_q;
        overflow_d = (b_q != TERM_CHAR);
        addr_d     = '0;
      end else begin
        w_data_d = b_q;
        addr_d   = addr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      cnt_q      <= '0;
      state_q    <= IDLE;
      s_q        <= '0;
      n_q        <= '0;
      b_q        <= '0;
      rx_done_q  <= 1'b0;
      ferr_q     <= 1'b0;
      we_q       <= 1'b0;
      w_addr_q   <= '0;
      w_data_q   <= '0;
      msg_done_q <= 1'b0;
      msg_len_q  <= '0;
      overflow_q <= 1'b0;
      addr_q     <= '0;
    end else begin
      rx_meta_q  <= rx;
      rx_sync_q  <= rx_meta_q;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      s_q        <= s_d;
      n_q        <= n_d;
      b_q        <= b_d;
      rx_done_q  <= rx_done_d;
      ferr_q     <= ferr_d;
      we_q       <= we_d;
      w_addr_q   <= w_addr_d;
      w_data_q   <= w_data_d;
      msg_done_q <= msg_done_d;
      msg_len_q  <= msg_len_d;
      overflow_q <= overflow_d;
      addr_q     <= addr_d;
    end
  end

  assign wr.we        = we_q;
  assign wr.w_addr    = w_addr_q;
  assign wr.w_data    = w_data_q;
  assign wr.msg_done  = msg_done_q;
  assign wr.msg_len   = msg_len_q;
  assign wr.overflow  = overflow_q;
  assign wr.frame_err = ferr_q;
endmodule

// File: tb/tb_uart_rx_capture.sv
// Directed plus randomized bench: serial frames are driven on rx and every BRAM
// write / message strobe is compared against an in-bench message model.
module tb_uart_rx_capture;
  localparam int         DVSR    = 4;
  localparam int         SB_TICK = 16;
  localparam int         AW      = 3;
  localparam int         CAP     = 1 << AW;
  localparam int         BIT     = 16 * DVSR;
  localparam logic [7:0] TERM    = 8'h0D;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic rx = 1'b1;

  always #5 clk = ~clk;

  uart_rx_capture_if #(.ADDR_WIDTH(AW)) wr ();

  uart_rx_capture #(
    .DVSR(DVSR), .SB_TICK(SB_TICK), .ADDR_WIDTH(AW), .TERM_CHAR(TERM)
  ) dut (
    .clk(clk), .reset_n(reset_n), .rx(rx), .wr(wr)
  );

  int checks = 0;
  int errors = 0;

  // Expected traffic: writes as {addr, data}, message ends as {overflow, len}.
  logic [AW+7:0] exp_wr_q[$];
  logic [AW:0]   exp_msg_q[$];
  int m_addr = 0;
  int exp_ferr = 0;
  int obs_ferr = 0;
  int obs_we = 0;
  int exp_we_total = 0;

  logic [AW-1:0] hold_addr, hold_len;
  logic [7:0]    hold_data;
  logic          hold_ovf, prev_ferr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Message semantics: bytes fill the buffer in order; the terminator or a full
  // buffer ends the message with a stored 0x00 and the next message starts at 0.
  function automatic void model_byte(input logic [7:0] b, input bit good);
    if (!good) begin
      exp_ferr++;
      return;
    end
    exp_we_total++;
    if (b == TERM || m_addr == CAP - 1) begin
      exp_wr_q.push_back({AW'(m_addr), 8'h00});
      exp_msg_q.push_back({(b != TERM), AW'(m_addr)});
      m_addr = 0;
    end else begin
      exp_wr_q.push_back({AW'(m_addr), b});
      m_addr++;
    end
  endfunction

  task automatic drive(input logic v, input int clks);
    #1 rx = v;
    repeat (clks) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit good, input int gap);
    model_byte(b, good);
    drive(1'b0, BIT);
    for (int i = 0; i < 8; i++) drive(b[i], BIT);
    if (good) begin
      drive(1'b1, BIT);
      drive(1'b1, gap);
    end else begin
      drive(1'b0, BIT / 2 + 12);
      drive(1'b1, BIT / 2 - 12 + BIT + gap);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {wr.we, wr.w_addr, wr.w_data, wr.msg_done, wr.msg_len, wr.overflow, wr.frame_err}, 0);
  endtask

  always @(negedge clk) begin
    if (!reset_n) begin
      hold_addr = '0;
      hold_data = '0;
      hold_len  = '0;
      hold_ovf  = 1'b0;
      prev_ferr = 1'b0;
    end else begin
      if (wr.we) begin
        obs_we++;
        check("we_expected", exp_wr_q.size() != 0, 1);
        if (exp_wr_q.size() != 0) begin
          logic [AW+7:0] e;
          e = exp_wr_q.pop_front();
          check("w_addr", wr.w_addr, e[AW+7:8]);
          check("w_data", wr.w_data, e[7:0]);
          $display("write addr=%0d data=%02h", wr.w_addr, wr.w_data);
          hold_addr = e[AW+7:8];
          hold_data = e[7:0];
        end
      end else begin
        check("w_hold", {wr.w_addr, wr.w_data}, {hold_addr, hold_data});
      end
      if (wr.msg_done) begin
        check("msg_done_we", wr.we, 1);
        check("msg_expected", exp_msg_q.size() != 0, 1);
        if (exp_msg_q.size() != 0) begin
          logic [AW:0] m;
          m = exp_msg_q.pop_front();
          check("msg_len", wr.msg_len, m[AW-1:0]);
          check("overflow", wr.overflow, m[AW]);
          $display("msg_done len=%0d overflow=%0b", wr.msg_len, wr.overflow);
          hold_len = m[AW-1:0];
          hold_ovf = m[AW];
        end
      end else begin
        check("msg_hold", {wr.msg_len, wr.overflow}, {hold_len, hold_ovf});
      end
      if (wr.frame_err) begin
        obs_ferr++;
        check("ferr_pulse", {prev_ferr, wr.we}, 2'b00);
        $display("frame_err");
      end
      prev_ferr = wr.frame_err;
    end
  end

  initial begin
    int we_before;
    int len;
    logic [7:0] b;

    // Reset state
    repeat (5) @(posedge clk);
    #1 check_all_zero("reset_state");
    @(negedge clk) reset_n = 1'b1;
    drive(1'b1, 2 * BIT);

    // "Hi" + CR
    send_frame(8'h48, 1'b1, BIT);
    send_frame(8'h69, 1'b1, BIT);
    send_frame(TERM, 1'b1, BIT);
    check("hi_len", wr.msg_len, 2);
    check("hi_ovf", wr.overflow, 0);

    // Short low glitch is rejected, next byte lands at address 0
    drive(1'b0, 4 * DVSR);
    drive(1'b1, 2 * BIT);
    send_frame(8'h41, 1'b1, BIT);
    send_frame(TERM, 1'b1, BIT);
    check("glitch_len", wr.msg_len, 1);

    // Stop bit low: byte dropped, next byte at the same address
    send_frame(8'h41, 1'b0, BIT);
    send_frame(8'h42, 1'b1, BIT);
    send_frame(TERM, 1'b1, BIT);
    check("ferr_len", wr.msg_len, 1);

    // Buffer overflow, then the CR forms an empty message
    for (int i = 0; i < CAP; i++) send_frame(8'h61 + 8'(i), 1'b1, BIT / 2);
    send_frame(TERM, 1'b1, BIT);
    check("empty_len", wr.msg_len, 0);
    check("empty_ovf", wr.overflow, 0);

    // Reset in the middle of data bit 4
    send_frame(8'h77, 1'b1, BIT);
    drive(1'b0, BIT);
    for (int i = 0; i < 4; i++) drive(1'(8'h55 >> i), BIT);
    drive(1'b1, BIT / 2);
    #1 reset_n = 1'b0;
    #1 check_all_zero("reset_mid_frame");
    exp_wr_q.delete();
    exp_msg_q.delete();
    m_addr = 0;
    rx = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    drive(1'b1, 2 * BIT);
    send_frame(8'h55, 1'b1, BIT);
    send_frame(TERM, 1'b1, BIT);
    check("after_reset_len", wr.msg_len, 1);

    // Back-to-back frames with zero idle gap
    we_before = obs_we;
    send_frame(8'h31, 1'b1, 0);
    send_frame(TERM, 1'b1, BIT);
    check("b2b_we_count", obs_we - we_before, 2);
    check("b2b_len", wr.msg_len, 1);

    // Randomized messages with occasional framing errors and random gaps
    for (int msg = 0; msg < 5; msg++) begin
      len = $urandom_range(0, CAP + 1);
      for (int k = 0; k < len; k++) begin
        b = 8'($urandom_range(0, 255));
        if (b == TERM) b = 8'h0E;
        send_frame(b, ($urandom_range(0, 7) != 0),
                   ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 2 * BIT));
      end
      send_frame(TERM, 1'b1, $urandom_range(0, BIT));
    end

    drive(1'b1, 3 * BIT);
    check("writes_drained", exp_wr_q.size(), 0);
    check("msgs_drained", exp_msg_q.size(), 0);
    check("ferr_count", obs_ferr, exp_ferr);
    check("we_total", obs_we, exp_we_total);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
